// File: rtl/i2s_pkg.sv
// Constants shared by the i2s slave and the i2s_master clock-master transceiver.
// Frame: 64 sclk, two 32-bit slots, 16-bit words MSB-first starting in slot 1.
package i2s_pkg;
  localparam int DATA_W      = 16;
  localparam int SLOT_W      = 32;
  localparam int FRAME_SLOTS = 64;
  localparam int SLOT_IDX_W  = $clog2(SLOT_W);
  localparam int BITCNT_W    = $clog2(FRAME_SLOTS);
  localparam int WORD_IDX_W  = $clog2(DATA_W);
  localparam logic [SLOT_IDX_W-1:0] FIRST_SLOT = SLOT_IDX_W'(1);
  localparam logic [SLOT_IDX_W-1:0] LAST_SLOT  = SLOT_IDX_W'(16);

  function automatic logic is_data_slot(input logic [SLOT_IDX_W-1:0] s);
    return (s >= FIRST_SLOT) && (s <= LAST_SLOT);
  endfunction
endpackage

// File: rtl/i2s_clkgen.sv
// Prescaler and slot counter producing sclk, lrclk and the per-edge ticks.
// Ticks flag the cycle whose clock edge moves sclk; free-running, no backpressure.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int DIV_LOG2 = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                sclk,
  output logic                lrclk,
  output logic [BITCNT_W-1:0] bitcnt,
  output logic                fall_tick,
  output logic                rise_tick
);
  localparam logic [DIV_LOG2:0] CNT_RISE = {1'b0, {DIV_LOG2{1'b1}}};

  logic [DIV_LOG2:0] cnt;

  assign fall_tick = (cnt == '1);
  assign rise_tick = (cnt == CNT_RISE);
  assign sclk      = cnt[DIV_LOG2];
  assign lrclk     = bitcnt[BITCNT_W-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt    <= '0;
      bitcnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (fall_tick) bitcnt <= bitcnt + 1'b1;
    end
  end
endmodule

// File: rtl/i2s_master.sv
// Clock-master I2S transceiver: 16-bit stereo TX/RX, one-frame loopback latency.
// No backpressure: IN_* sampled and OUT_* updated on the i2s_sampled strobe.
module i2s_master
  import i2s_pkg::*;
#(
  parameter int DIV_LOG2 = 3
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] IN_L,
  input  logic signed [DATA_W-1:0] IN_R,
  output logic                     i2s_sclk,
  output logic                     i2s_lrclk,
  output logic                     i2s_dout,
  input  logic                     i2s_din,
  output logic signed [DATA_W-1:0] OUT_L,
  output logic signed [DATA_W-1:0] OUT_R,
  output logic                     i2s_sampled
);
  logic [BITCNT_W-1:0]   bitcnt;
  logic [BITCNT_W-1:0]   bitcnt_nxt;
  logic [SLOT_IDX_W-1:0] slot_nxt;
  logic [WORD_IDX_W-1:0] tx_idx;
  logic [DATA_W-1:0]     tx_word;
  logic [DATA_W-1:0]     hold_l, hold_r;
  logic [DATA_W-1:0]     rx_l, rx_r;
  logic                  fall_tick, rise_tick, frame_end, tx_bit;

  i2s_clkgen #(.DIV_LOG2(DIV_LOG2)) u_clkgen (
    .clk       (CLK),
    .reset_n   (reset_n),
    .sclk      (i2s_sclk),
    .lrclk     (i2s_lrclk),
    .bitcnt    (bitcnt),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  // dout is loaded on the fall tick, so it is computed for the slot that tick enters.
  always_comb begin
    bitcnt_nxt = bitcnt + 1'b1;
    slot_nxt   = bitcnt_nxt[SLOT_IDX_W-1:0];
    tx_word    = bitcnt_nxt[BITCNT_W-1] ? hold_r : hold_l;
    tx_idx     = WORD_IDX_W'(LAST_SLOT - slot_nxt);
    tx_bit     = is_data_slot(slot_nxt) ? tx_word[tx_idx] : 1'b0;
  end

  assign frame_end = fall_tick && (bitcnt == '1);

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      i2s_dout    <= 1'b0;
      i2s_sampled <= 1'b0;
      hold_l      <= '0;
      hold_r      <= '0;
      rx_l        <= '0;
      rx_r        <= '0;
      OUT_L       <= '0;
      OUT_R       <= '0;
    end else begin
      i2s_sampled <= 1'b0;
      if (rise_tick && is_data_slot(bitcnt[SLOT_IDX_W-1:0])) begin
        if (bitcnt[BITCNT_W-1]) rx_r <= {rx_r[DATA_W-2:0], i2s_din};
        else                    rx_l <= {rx_l[DATA_W-2:0], i2s_din};
      end
      if (fall_tick) i2s_dout <= tx_bit;
      if (frame_end) begin
        hold_l      <= IN_L;
        hold_r      <= IN_R;
        OUT_L       <= rx_l;
        OUT_R       <= rx_r;
        i2s_sampled <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_i2s_master.sv
// Bench for i2s_master at DIV_LOG2=3 and DIV_LOG2=1, both instances in loopback.
module tb_i2s_master;
  localparam int DIV_A = 3;
  localparam int DIV_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, sel;
  logic signed [15:0] in_l, in_r;
  logic sclk_a, lr_a, dout_a, smp_a, sclk_b, lr_b, dout_b, smp_b;
  logic signed [15:0] outl_a, outr_a, outl_b, outr_b;
  logic sclk_x, lr_x, dout_x, smp_x;
  logic [15:0] ol_x, or_x;

  assign sclk_x = sel ? sclk_b : sclk_a;
  assign lr_x   = sel ? lr_b   : lr_a;
  assign dout_x = sel ? dout_b : dout_a;
  assign smp_x  = sel ? smp_b  : smp_a;
  assign ol_x   = sel ? outl_b : outl_a;
  assign or_x   = sel ? outr_b : outr_a;

  i2s_master #(.DIV_LOG2(DIV_A)) dut_a (
    .CLK(clk), .reset_n(rst_a), .IN_L(in_l), .IN_R(in_r),
    .i2s_sclk(sclk_a), .i2s_lrclk(lr_a), .i2s_dout(dout_a), .i2s_din(dout_a),
    .OUT_L(outl_a), .OUT_R(outr_a), .i2s_sampled(smp_a)
  );

  i2s_master #(.DIV_LOG2(DIV_B)) dut_b (
    .CLK(clk), .reset_n(rst_b), .IN_L(in_l), .IN_R(in_r),
    .i2s_sclk(sclk_b), .i2s_lrclk(lr_b), .i2s_dout(dout_b), .i2s_din(dout_b),
    .OUT_L(outl_b), .OUT_R(outr_b), .i2s_sampled(smp_b)
  );

  typedef struct {
    logic [15:0] il, ir, el, er;
  } vec_t;
  vec_t tbl[6];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_rst(input logic v);
    if (sel) rst_b = v;
    else     rst_a = v;
  endtask

  // Expected dout per slot of one frame, slot 0 in bit 63.
  function automatic logic [63:0] frame_model(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] v;
    logic [15:0] w;
    int s;
    v = '0;
    for (int p = 0; p < 64; p++) begin
      s = p % 32;
      w = (p < 32) ? l : r;
      if (s >= 1 && s <= 16) v[63-p] = w[16-s];
    end
    return v;
  endfunction

  task automatic hold_reset(input int ncyc);
    int bad;
    bad = 0;
    @(negedge clk);
    set_rst(1'b0);
    repeat (ncyc) begin
      @(negedge clk);
      if ({sclk_x, lr_x, dout_x, smp_x, ol_x, or_x} != 36'd0) bad++;
    end
    chk("outputs_zero_in_reset", 64'(bad), 64'd0);
    set_rst(1'b1);
  endtask

  task automatic wait_strobe(input int budget, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (smp_x) ok = 1'b1;
    end
  endtask

  // Starts right after reset release with IN held; watches 3 frames plus one slot.
  task automatic shape_check(input int div, input logic [15:0] l, input logic [15:0] r);
    int half, slot, frame, bad, misal;
    int rises[$], falls[$], lrs[$], strobes[$];
    bit dbits[$];
    logic [31:0] outs[$];
    logic ps, pl;
    logic [63:0] f1, f2;
    half = 1 << div;
    slot = 2 * half;
    frame = 64 * slot;
    misal = 0;
    ps = 1'b0;
    pl = 1'b0;
    for (int n = 1; n <= 3 * frame + slot; n++) begin
      @(negedge clk);
      if (sclk_x && !ps) begin rises.push_back(n); dbits.push_back(dout_x); end
      if (!sclk_x && ps) falls.push_back(n);
      if (lr_x != pl) begin
        lrs.push_back(n);
        if (!(ps && !sclk_x)) misal++;
      end
      if (smp_x) begin strobes.push_back(n); outs.push_back({ol_x, or_x}); end
      ps = sclk_x;
      pl = lr_x;
    end
    chk("sclk_rise_count", 64'(rises.size()), 64'd193);
    chk("first_sclk_rise", 64'(rises.size() > 0 ? rises[0] : -1), 64'(half));
    bad = 0;
    for (int k = 0; k + 1 < rises.size(); k++) if (rises[k+1] - rises[k] != slot) bad++;
    for (int k = 0; k < falls.size() && k < rises.size(); k++) if (falls[k] - rises[k] != half) bad++;
    chk("sclk_period_duty", 64'(bad), 64'd0);
    chk("lrclk_toggle_count", 64'(lrs.size()), 64'd6);
    bad = 0;
    for (int k = 0; k < lrs.size(); k++) if (lrs[k] != (k + 1) * 32 * slot) bad++;
    chk("lrclk_period", 64'(bad), 64'd0);
    chk("lrclk_on_sclk_fall", 64'(misal), 64'd0);
    chk("strobe_count", 64'(strobes.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      chk("strobe_time", 64'(k < strobes.size() ? strobes[k] : -1), 64'((k + 1) * frame));
    f1 = '0;
    f2 = '0;
    for (int p = 0; p < 64; p++) begin
      if (64 + p < dbits.size()) begin
        f1[63-p] = dbits[p];
        f2[63-p] = dbits[64+p];
      end
    end
    chk("tx_frame1_zeros", f1, frame_model(16'h0, 16'h0));
    chk("tx_frame2_bits", f2, frame_model(l, r));
    chk("out_strobe1_zero", 64'(outs.size() > 0 ? outs[0] : 32'hDEAD_BEEF), 64'd0);
    chk("out_strobe2_loop", 64'(outs.size() > 1 ? outs[1] : 32'hDEAD_BEEF), 64'({l, r}));
  endtask

  task automatic ramp_table(input int frame);
    int n;
    bit ok;
    in_l = tbl[0].il;
    in_r = tbl[0].ir;
    hold_reset(4);
    for (int k = 0; k < 6; k++) begin
      wait_strobe(frame + 8, n, ok);
      chk("ramp_strobe_period", 64'(ok ? n : -1), 64'(frame));
      chk("ramp_out", 64'({ol_x, or_x}), 64'({tbl[k].el, tbl[k].er}));
      if (k < 5) begin
        in_l = tbl[k+1].il;
        in_r = tbl[k+1].ir;
      end
    end
  endtask

  initial begin
    int n, frame_a;
    bit ok;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    rst_a = 1'b0;
    rst_b = 1'b0;
    sel   = 1'b0;
    in_l  = 16'sh0;
    in_r  = 16'sh0;
    frame_a = 64 * (2 << DIV_A);

    tbl[0] = '{16'h7FFE, 16'h0002, 16'h0000, 16'h0000};
    tbl[1] = '{16'h7FFF, 16'h0001, 16'h7FFE, 16'h0002};
    tbl[2] = '{16'h8000, 16'h0000, 16'h7FFF, 16'h0001};
    tbl[3] = '{16'h8001, 16'hFFFF, 16'h8000, 16'h0000};
    tbl[4] = '{16'h8002, 16'hFFFE, 16'h8001, 16'hFFFF};
    tbl[5] = '{16'h8003, 16'hFFFD, 16'h8002, 16'hFFFE};

    in_l = 16'hA5C3;
    in_r = 16'h1234;
    hold_reset(10);
    shape_check(DIV_A, 16'hA5C3, 16'h1234);

    ramp_table(frame_a);

    // Random samples through loopback, expected values from a FIFO of captured inputs.
    exp_q.push_back({tbl[5].il, tbl[5].ir});
    for (int i = 0; i < 8; i++) begin
      in_l = 16'($urandom);
      in_r = 16'($urandom);
      exp_q.push_back({in_l, in_r});
      wait_strobe(frame_a + 8, n, ok);
      chk("rand_strobe_period", 64'(ok ? n : -1), 64'(frame_a));
      e = exp_q.pop_front();
      chk("rand_loop_out", 64'({ol_x, or_x}), 64'(e));
    end

    in_l = 16'h1357;
    in_r = 16'h2468;
    wait_strobe(frame_a + 8, n, ok);
    e = exp_q.pop_front();
    chk("pre_reset_out", 64'({ol_x, or_x}), 64'(e));
    wait_strobe(frame_a + 8, n, ok);
    chk("pre_reset_known_out", 64'({ol_x, or_x}), 64'({16'h1357, 16'h2468}));

    // hold_reset adds one cycle, landing the reset inside bitcnt 40.
    repeat (40 * (2 << DIV_A) - 1) @(negedge clk);
    hold_reset(3);
    wait_strobe(frame_a + 8, n, ok);
    chk("post_reset_first_strobe", 64'(ok ? n : -1), 64'(frame_a));
    chk("post_reset_out_zero", 64'({ol_x, or_x}), 64'd0);
    wait_strobe(frame_a + 8, n, ok);
    chk("post_reset_loop_out", 64'({ol_x, or_x}), 64'({16'h1357, 16'h2468}));

    set_rst(1'b0);
    sel  = 1'b1;
    in_l = 16'h8001;
    in_r = 16'h7FFE;
    hold_reset(10);
    shape_check(DIV_B, 16'h8001, 16'h7FFE);
    ramp_table(64 * (2 << DIV_B));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2s_master.md
# i2s_master

Clock-master I2S transceiver for 16-bit stereo audio. It generates bit clock and word select from the system clock and shifts out parallel left/right samples. It also deserializes the returning data line into parallel samples. It is the opposite end of the existing `i2s` slave interface and drives external codecs or that slave directly, with the same 32-bit slot, 64-sclk frame format.

## Interface
- `DIV_LOG2`, default 3: sclk half-period is 2^DIV_LOG2 CLK cycles, so sclk = CLK/16 by default.
- `CLK`  in  1  system clock; every register updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `IN_L`  in  16  signed left sample to transmit.
- `IN_R`  in  16  signed right sample to transmit.
- `i2s_sclk`  out  1  bit clock.
- `i2s_lrclk`  out  1  word select: 0 = left, 1 = right.
- `i2s_dout`  out  1  serial data to the codec.
- `i2s_din`  in  1  serial data from the codec.
- `OUT_L`  out  16  signed left sample received.
- `OUT_R`  out  16  signed right sample received.
- `i2s_sampled`  out  1  one-CLK strobe at each frame boundary.

## Operation
- **Prescaler `cnt`**
  - Width DIV_LOG2+1; increments every CLK and wraps.
  - `i2s_sclk` = cnt[DIV_LOG2], so sclk is low for the first half of the count and high for the second.
- **Slot counter `bitcnt`**
  - 6-bit; increments on the fall tick (cnt = all ones) and wraps 63→0.
  - `i2s_lrclk` = bitcnt[5].
  - Slot s = bitcnt[4:0] within the current half-frame.
- **Transmit**, standard I2S with one-bit delay, MSB first.
  - In slot s = 1..16, `i2s_dout` = word[16−s]; word is the left sample when bitcnt[5] = 0, the right sample when bitcnt[5] = 1.
  - Slots 0 and 17..31 drive 0.
  - `i2s_dout` changes only on fall ticks, in the same CLK edge as sclk falling.
- **Receive**
  - `i2s_din` is registered on the rise tick (cnt = 2^DIV_LOG2 − 1) in slots 1..16 and shifted in MSB first.
  - Slots 0 and 17..31 are ignored.
  - The left word is complete after the rise in slot 16 (bitcnt 16); the right word after slot 48.
- **Frame boundary**: the fall tick with bitcnt 63→0. In that single CLK cycle:
  - IN_L/IN_R are captured into the transmit holding registers and used for the frame now starting.
  - The completed left/right receive words are copied to OUT_L/OUT_R.
  - `i2s_sampled` pulses high for exactly one CLK.
- **Upstream contract**: upstream may change IN_* in response to `i2s_sampled`. Those values are used in the following frame.
- **Reset**: mid-frame reset abandons the frame. No partial word reaches OUT_*. After reset release, counting restarts from bitcnt 0.

## Timing
- **Reset values**: cnt=0, bitcnt=0, i2s_sclk=0, i2s_lrclk=0, i2s_dout=0, OUT_L=OUT_R=0, i2s_sampled=0, holding and shift registers 0.
- **Derived periods** (default DIV_LOG2=3):
  - 16 CLK per slot; 1024 CLK per frame.
  - First `i2s_sampled` is 1024 CLK after the first cycle with reset_n=1.
  - Strobes then repeat every 1024 CLK.
- **Outputs are all registered**:
  - `i2s_lrclk` transitions coincide with sclk falling edges.
  - `i2s_dout` is stable for a full sclk period around each rising edge.
- **Loopback latency** (din tied to dout): OUT_* at strobe k+1 equals IN_* captured at strobe k, which is exactly one frame.
- **First frame after reset** transmits zeros, so OUT_* stays 0 at strobe 1.
- **Simultaneous events**: a fall tick that is also the frame boundary performs the IN capture, OUT update, strobe, lrclk change and dout update in the same edge.

## Structure
- **Shared package `i2s_pkg`** holds the constants common to `i2s` and `i2s_master`:
  - data width 16
  - slot width 32
  - frame slots 64
  - first data slot 1
  - last data slot 16
- **Sub-module `i2s_clkgen`**:
  - Contains the prescaler and slot counter.
  - Outputs sclk, lrclk, bitcnt, fall_tick and rise_tick.
  - The top level contains the TX/RX shifters and output registers.

## Test plan
- **Reset**: hold reset_n=0 for 10 CLK.
  - All outputs stay 0.
  - After release, the first sclk rise is at CLK 8 and the first `i2s_sampled` at CLK 1024.
- **Clock shape**: sclk period is 16 CLK at 50% duty; lrclk period is 1024 CLK; lrclk edges align with sclk falls.
- **TX format**:
  - Stimulus: IN_L=16'hA5C3, IN_R=16'h1234 held.
  - In frame 2, dout reads 0 in slot 0, then 1010010111000011 in slots 1..16, then 0 in slots 17..31.
  - The right half carries 0001001000110100.
- **Loopback ramp**:
  - Stimulus: din=dout, with IN_L incrementing and IN_R decrementing on each strobe.
  - OUT_L/OUT_R equal the IN values from one strobe earlier, including the wrap 16'h7FFF→16'h8000 and 16'h0000→16'hFFFF.
- **Mid-frame reset**: assert reset_n=0 at bitcnt 40 for 3 CLK.
  - OUT_* return to 0 with no strobe.
  - The next strobe comes exactly 1024 CLK after release.
- **DIV_LOG2=1**: sclk period is 4 CLK and the strobe period is 256 CLK; the loopback ramp still passes.
